// File: rtl/uart_rx.sv
// uart_rx: receive-side 8N1 UART peripheral on the CPU memory bus.
// Bytes pass through a two-flop synchroniser and a bit-timing FSM into a
// small circular FIFO. The CPU reads DATA / STATUS / LEVEL registers using the
// common rd_en/wr_en handshake, with rd_valid one cycle after rd_en.
module uart_rx #(
  parameter int DIV   = 104,  // clk cycles per bit, >= 4
  parameter int DEPTH = 16    // FIFO entries, power of two, >= 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] addr,
  input  logic       rd_en,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  input  logic       rx,
  output logic       irq
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int AW    = $clog2(DEPTH);
  localparam int PW    = AW + 1;  // one extra bit tells full from empty

  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(DIV / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(DIV - 1);

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_LEVEL  = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_e;

  // ---------------------------------------------------------------------------
  // Signals
  // ---------------------------------------------------------------------------
  logic             rx_meta_q, rxs_q;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             push_req;
  logic             ferr_set;

  logic [7:0]       mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [PW-1:0]    count;
  logic [31:0]      count_ext;
  logic [7:0]       level;
  logic             empty, full;
  logic             push, pop;

  logic             overrun_q, overrun_d;
  logic             ferr_q, ferr_d;
  logic             overrun_set;
  logic             status_wr;
  logic             data_rd;

  logic [7:0]       rd_mux;
  logic [7:0]       rd_data_q;
  logic             rd_valid_q;

  // Upper address bits and write data carry no information for this block.
  logic             unused_bus;
  assign unused_bus = ^{addr[4:2], wr_data};

  // ---------------------------------------------------------------------------
  // Input synchroniser
  // ---------------------------------------------------------------------------
  // Two-flop synchroniser for the asynchronous rx pin; idles high.
  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples the pre-edge value of its neighbours, exactly like hardware.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rxs_q     <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rxs_q     <= rx_meta_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Receive FSM
  // ---------------------------------------------------------------------------
  // FSM state, bit-timing counter, bit index and shift register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

  // Next-state logic: start-bit qualification, mid-bit sampling, stop check.
  // NOTE: every variable written here gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    push_req = 1'b0;
    ferr_set = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!rxs_q) begin
          state_d = S_START;
          cnt_d   = '0;
        end
      end
      S_START: begin
        // Re-check the line half a bit in; a short low pulse is a glitch.
        if (cnt_q == HALF_M1) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rxs_q ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          shift_d = {rxs_q, shift_q[7:1]};  // LSB first
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d = '0;
          if (rxs_q) begin
            push_req = 1'b1;
            state_d  = S_IDLE;
          end else begin
            ferr_set = 1'b1;
            state_d  = S_BREAK;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_BREAK: begin
        // A line held low reports one framing error, not one per frame time.
        if (rxs_q) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------------------
  assign count     = wr_ptr_q - rd_ptr_q;
  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign full      = (count == PW'(DEPTH));
  assign count_ext = 32'(count);
  assign level     = (count_ext > 32'd255) ? 8'hFF : count_ext[7:0];

  assign status_wr   = wr_en && (addr[1:0] == REG_STATUS);
  assign data_rd     = rd_en && (addr[1:0] == REG_DATA);
  // Fullness is judged before any same-cycle pop: a full FIFO refuses the byte.
  assign push        = push_req && !full;
  assign overrun_set = push_req && full;
  assign pop         = data_rd && !empty;

  // Storage array, written on an accepted push.
  // NOTE: the storage array has no reset; the pointers alone define which
  // entries are valid, and an unreset array maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= shift_q;
    end
  end

  // Read and write pointers; push and pop in one cycle both advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Sticky status flags: a set event beats a same-cycle clear
  // ---------------------------------------------------------------------------
  assign overrun_d = overrun_set || (overrun_q && !status_wr);
  assign ferr_d    = ferr_set    || (ferr_q    && !status_wr);

  // Sticky overrun and framing-error flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun_q <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      overrun_q <= overrun_d;
      ferr_q    <= ferr_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Bus read path
  // ---------------------------------------------------------------------------
  // Register read multiplexer, evaluated on pre-edge state.
  always_comb begin
    rd_mux = 8'h00;
    case (addr[1:0])
      REG_DATA:   rd_mux = empty ? 8'h00 : mem_q[rd_ptr_q[AW-1:0]];
      REG_STATUS: rd_mux = {5'b0, ferr_q, overrun_q, !empty};
      REG_LEVEL:  rd_mux = level;
      default:    rd_mux = 8'h00;
    endcase
  end

  // Read response: data is captured on rd_en and held until the next read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q  <= 8'h00;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_en;
      if (rd_en) begin
        rd_data_q <= rd_mux;
      end
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  // Driven only by the FIFO pointer flops, so there is no combinational path from rx.
  assign irq      = !empty;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed self-checking bench for uart_rx (DIV=8, DEPTH=4).
// Inputs change on the falling clock edge; outputs are sampled there too.
module tb_uart_rx;

  localparam int DIV      = 8;
  localparam int DEPTH    = 4;
  // Frame cycle (counted from the cycle rx first goes low) whose rising edge
  // pushes the byte: 2 sync flops + half bit + 9 full bits.
  localparam int PUSH_CYC = 2 + DIV / 2 + 9 * DIV;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] addr;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       rx;
  logic       irq;

  int total = 0;
  int bad   = 0;

  logic [7:0] got;
  logic [7:0] dummy;

  uart_rx #(.DIV(DIV), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .addr     (addr),
    .rd_en    (rd_en),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .rx       (rx),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One-cycle read strobe; returns what the bus shows in the following cycle.
  task automatic do_read(input logic [1:0] a, output logic [7:0] d, output logic v);
    addr  = {3'b000, a};
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    d     = rd_data;
    v     = rd_valid;
  endtask

  task automatic read_check(input logic [1:0] a, input logic [7:0] exp, input string tag);
    logic [7:0] d;
    logic       v;
    do_read(a, d, v);
    check({tag, "_valid"}, {7'd0, v}, 8'h01);
    check(tag, d, exp);
  endtask

  task automatic write_status(input logic [7:0] d);
    addr    = 5'd1;
    wr_data = d;
    wr_en   = 1'b1;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  // Sends one frame; optionally strobes a DATA read in frame cycle rd_at.
  task automatic send_frame(input logic [7:0] b, input logic stop, input int rd_at,
                            output logic [7:0] rd_byte);
    logic [9:0] bits;
    bits    = {stop, b, 1'b0};
    rd_byte = 8'h00;
    for (int c = 0; c < 10 * DIV; c++) begin
      rx = bits[c / DIV];
      if (c == rd_at) begin
        addr  = 5'd0;
        rd_en = 1'b1;
      end else begin
        rd_en = 1'b0;
      end
      if (c == rd_at + 1) rd_byte = rd_data;
      @(negedge clk);
    end
    rd_en = 1'b0;
  endtask

  initial begin
    logic [9:0] pbits;
    rst_n   = 1'b0;
    rx      = 1'b1;
    addr    = 5'd0;
    rd_en   = 1'b0;
    wr_en   = 1'b0;
    wr_data = 8'h00;
    idle(3);

    // Reset state
    check("rst_rd_data", rd_data, 8'h00);
    check("rst_rd_valid", {7'd0, rd_valid}, 8'h00);
    check("rst_irq", {7'd0, irq}, 8'h00);
    rst_n = 1'b1;
    idle(4);
    read_check(2'd2, 8'h00, "rst_level");
    read_check(2'd1, 8'h00, "rst_status");

    // 1: single frame 0xA5
    send_frame(8'hA5, 1'b1, -1, dummy);
    idle(2);
    check("t1_irq_set", {7'd0, irq}, 8'h01);
    read_check(2'd0, 8'hA5, "t1_data");
    check("t1_irq_clr", {7'd0, irq}, 8'h00);
    idle(1);
    check("t1_valid_one_cycle", {7'd0, rd_valid}, 8'h00);
    check("t1_data_held", rd_data, 8'hA5);
    read_check(2'd2, 8'h00, "t1_level");

    // 2: five frames into a four-entry FIFO
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, -1, dummy);
    idle(2);
    read_check(2'd2, 8'h04, "t2_level");
    read_check(2'd1, 8'h03, "t2_status");
    read_check(2'd0, 8'h01, "t2_data1");
    read_check(2'd0, 8'h02, "t2_data2");
    read_check(2'd0, 8'h03, "t2_data3");
    read_check(2'd0, 8'h04, "t2_data4");
    read_check(2'd0, 8'h00, "t2_empty_read");
    read_check(2'd2, 8'h00, "t2_level_empty");
    write_status(8'h00);
    read_check(2'd1, 8'h00, "t2_status_cleared");
    read_check(2'd3, 8'h00, "t2_reserved");

    // 3: bad stop bit, then a long break, then a good frame
    send_frame(8'h3C, 1'b0, -1, dummy);
    idle(2);
    read_check(2'd1, 8'h04, "t3_frame_err");
    read_check(2'd2, 8'h00, "t3_level");
    write_status(8'hFF);
    idle(40);
    rx = 1'b1;
    idle(2 * DIV);
    send_frame(8'h55, 1'b1, -1, dummy);
    idle(2);
    read_check(2'd1, 8'h01, "t3_single_error");
    read_check(2'd0, 8'h55, "t3_after_break");

    // 4: short glitch is ignored
    rx = 1'b0;
    idle(2);
    rx = 1'b1;
    idle(3 * DIV);
    check("t4_irq", {7'd0, irq}, 8'h00);
    read_check(2'd1, 8'h00, "t4_status");
    read_check(2'd2, 8'h00, "t4_level");

    // 5: pop coinciding with a push into a full FIFO, then into 3 entries
    send_frame(8'h11, 1'b1, -1, dummy);
    send_frame(8'h22, 1'b1, -1, dummy);
    send_frame(8'h33, 1'b1, -1, dummy);
    send_frame(8'h44, 1'b1, -1, dummy);
    idle(2);
    read_check(2'd2, 8'h04, "t5_full_level");
    send_frame(8'h55, 1'b1, PUSH_CYC, got);
    check("t5_pop_full", got, 8'h11);
    idle(2);
    read_check(2'd2, 8'h03, "t5_level_after_refuse");
    read_check(2'd1, 8'h03, "t5_overrun");
    write_status(8'h00);
    send_frame(8'h66, 1'b1, PUSH_CYC, got);
    check("t5_pop_three", got, 8'h22);
    idle(2);
    read_check(2'd2, 8'h03, "t5_level_push_pop");
    read_check(2'd1, 8'h01, "t5_no_overrun");
    read_check(2'd0, 8'h33, "t5_drain1");
    read_check(2'd0, 8'h44, "t5_drain2");
    read_check(2'd0, 8'h66, "t5_drain3");

    // 6: reset during bit 4 of a frame
    send_frame(8'h99, 1'b1, -1, dummy);
    idle(2);
    check("t6_irq_before", {7'd0, irq}, 8'h01);
    pbits = {1'b1, 8'h7E, 1'b0};
    for (int c = 0; c < 5 * DIV + DIV / 2; c++) begin
      rx = pbits[c / DIV];
      @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    check("t6_rd_data_rst", rd_data, 8'h00);
    check("t6_rd_valid_rst", {7'd0, rd_valid}, 8'h00);
    check("t6_irq_rst", {7'd0, irq}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    rx    = 1'b1;
    idle(2 * DIV);
    read_check(2'd2, 8'h00, "t6_level_after_rst");
    send_frame(8'h7E, 1'b1, -1, dummy);
    idle(2);
    read_check(2'd1, 8'h01, "t6_status");
    read_check(2'd0, 8'h7E, "t6_data");
    read_check(2'd2, 8'h00, "t6_level_end");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
